// File: rtl/arbiter_8x3.sv
// ============================================================================
// Module      : arbiter_8x3
// Description : 8-requester round-robin arbiter with bounded hold time,
//               registered one-hot/binary grant and forced-release pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_8x3 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_ptr, w_ptr_nxt;
    logic [7:0] r_hold, w_hold_nxt;
    logic [7:0] r_gnt, w_gnt_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_timeout, w_timeout_nxt;

    logic       w_found;
    logic [2:0] w_winner;

    // Scan upward from the pointer; 3-bit addition gives the 7->0 wrap.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!w_found && req[3'(r_ptr + 3'(k))]) begin
                w_found  = 1'b1;
                w_winner = r_ptr + 3'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_gnt_nxt     = r_gnt;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = 8'b1 << w_winner;
                    w_idx_nxt   = w_winner;
                    w_valid_nxt = 1'b1;
                    w_ptr_nxt   = w_winner + 3'd1;
                    w_hold_nxt  = 8'd0;
                end
            end
            S_GRANT: begin
                // A dropped request wins over the hold limit, so no pulse then.
                if (!req[r_idx] || (r_hold == c_hold_last)) begin
                    w_state_nxt   = S_RECOVER;
                    w_gnt_nxt     = 8'd0;
                    w_idx_nxt     = 3'd0;
                    w_valid_nxt   = 1'b0;
                    w_timeout_nxt = req[r_idx];
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            S_RECOVER: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 8'd0;
                w_idx_nxt   = 3'd0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'd0;
            r_hold    <= 8'd0;
            r_gnt     <= 8'd0;
            r_idx     <= 3'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_gnt     <= w_gnt_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;
    assign timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_arbiter_8x3.sv
// ============================================================================
// Module      : tb_arbiter_8x3
// Description : Self-checking bench for arbiter_8x3 against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbiter_8x3;

    localparam int MH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_tests;
    int n_fail;

    // Reference model: owner of the grant (-1 = none), next search start,
    // cycles already granted, recovery flag and timeout pulse.
    int m_owner;
    int m_next;
    int m_held;
    bit m_rec;
    bit m_to;

    arbiter_8x3 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] exp_vec();
        if (m_owner >= 0)
            return {8'(1 << m_owner), 3'(m_owner), 1'b1, m_to};
        return {8'h00, 3'd0, 1'b0, m_to};
    endfunction

    task automatic model_edge(input logic r, input logic [7:0] rv);
        if (r) begin
            m_owner = -1; m_next = 0; m_held = 0; m_rec = 0; m_to = 0;
        end else if (m_rec) begin
            m_rec = 0; m_to = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            for (int k = 0; k < 8; k++) begin
                int i;
                i = (m_next + k) % 8;
                if (rv[i]) begin
                    m_owner = i; m_next = (i + 1) % 8; m_held = 1;
                    break;
                end
            end
        end else if (!rv[m_owner]) begin
            m_owner = -1; m_rec = 1; m_to = 0;
        end else if (m_held == MH) begin
            m_owner = -1; m_rec = 1; m_to = 1;
        end else begin
            m_held++;
        end
    endtask

    task automatic tick(input logic r, input logic [7:0] rv);
        @(negedge clk);
        rst = r;
        req = rv;
        @(posedge clk);
        model_edge(r, rv);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'hFF);
        n_tests++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0000", {gnt, gnt_idx, gnt_valid, timeout});
        end
    endtask

    task automatic test_single_grant();
        logic [7:0] seq [5] = '{8'h02, 8'h02, 8'h02, 8'h00, 8'h00};
        logic [12:0] want [5] = '{{8'h02, 3'd1, 1'b1, 1'b0}, {8'h02, 3'd1, 1'b1, 1'b0},
                                  {8'h02, 3'd1, 1'b1, 1'b0}, 13'd0, 13'd0};
        tick(1'b1, 8'h00);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, seq[c]);
            n_tests++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== want[c] || want[c] !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_grant c%0d: got %h required %h (model %h)", c,
                         {gnt, gnt_idx, gnt_valid, timeout}, want[c], exp_vec());
            end
        end
    endtask

    task automatic test_round_robin();
        tick(1'b1, 8'h00);
        tick(1'b0, 8'h28);
        n_tests++;
        if (gnt_idx !== 3'd3 || gnt !== 8'h08) begin
            n_fail++;
            $display("FAIL rr_first: got idx %0d gnt %h required idx 3 gnt 08", gnt_idx, gnt);
        end
        tick(1'b0, 8'h20);
        tick(1'b0, 8'h28);
        tick(1'b0, 8'h28);
        n_tests++;
        if (gnt_idx !== 3'd5 || gnt !== 8'h20 || {gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
            n_fail++;
            $display("FAIL rr_second: got idx %0d gnt %h required idx 5 gnt 20", gnt_idx, gnt);
        end
    endtask

    task automatic test_timeout_rotation();
        int  order[$];
        int  runlen;
        bit  prev_valid;
        tick(1'b1, 8'h00);
        runlen = 0;
        prev_valid = 0;
        for (int c = 0; c < 64; c++) begin
            tick(1'b0, 8'hFF);
            n_tests++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                n_fail++;
                $display("FAIL rotation_cycle c%0d: got %h required %h", c,
                         {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
            end
            if (gnt_valid && !prev_valid) begin
                order.push_back(int'(gnt_idx));
                runlen = 1;
            end else if (gnt_valid) begin
                runlen++;
            end else if (prev_valid) begin
                n_tests++;
                if (runlen != MH || timeout !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rotation_hold: got len %0d timeout %b required len %0d timeout 1",
                             runlen, timeout, MH);
                end
            end
            prev_valid = gnt_valid;
        end
        for (int g = 0; g < 9; g++) begin
            n_tests++;
            if (g >= order.size() || order[g] != g % 8) begin
                n_fail++;
                $display("FAIL rotation_order g%0d: got %0d required %0d", g,
                         (g < order.size()) ? order[g] : -1, g % 8);
            end
        end
    endtask

    task automatic test_wrap();
        tick(1'b1, 8'h00);
        tick(1'b0, 8'h80);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h41);
        n_tests++;
        if (gnt_idx !== 3'd0 || gnt !== 8'h01 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap: got idx %0d gnt %h required idx 0 gnt 01", gnt_idx, gnt);
        end
    endtask

    task automatic test_drop_at_limit();
        tick(1'b1, 8'h00);
        for (int c = 0; c < MH; c++) tick(1'b0, 8'h04);
        tick(1'b0, 8'h00);
        n_tests++;
        if (timeout !== 1'b0 || gnt !== 8'h00 || gnt_valid !== 1'b0 || exp_vec() !== 13'd0) begin
            n_fail++;
            $display("FAIL drop_at_limit: got timeout %b gnt %h required timeout 0 gnt 00", timeout, gnt);
        end
    endtask

    task automatic test_reset_mid_grant();
        tick(1'b1, 8'h00);
        tick(1'b0, 8'h20);
        tick(1'b0, 8'h20);
        tick(1'b1, 8'h20);
        n_tests++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_grant: got gnt %h valid %b timeout %b required 00 0 0",
                     gnt, gnt_valid, timeout);
        end
        tick(1'b0, 8'hFF);
        n_tests++;
        if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_then_ff: got idx %0d gnt %h required idx 0 gnt 01", gnt_idx, gnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] rv;
        logic       rr;
        rv = 8'h00;
        tick(1'b1, 8'h00);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) rv = 8'($urandom);
            rr = ($urandom_range(0, 49) == 0);
            tick(rr, rv);
            n_tests++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec() ||
                (gnt_valid && gnt !== (8'h01 << gnt_idx))) begin
                n_fail++;
                $display("FAIL random c%0d req %h: got %h required %h", c, rv,
                         {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        req = 8'h00;
        m_owner = -1; m_next = 0; m_held = 0; m_rec = 0; m_to = 0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_timeout_rotation();
        test_wrap();
        test_drop_at_limit();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
